// File: rtl/ul_tdm_sched_if.sv
// Bus bundle for ul_tdm_sched: run control, slot config, requester handshakes and TDM output.
// Optional o_underrun_cnt exists only when UL_TDM_UNDERRUN_CNT_EN is defined.
interface ul_tdm_sched_if #(
  parameter int NSRC = 4,
  parameter int W    = 32
);
  logic                i_en;
  logic [15:0]         i_slot_map;
  logic [7:0]          i_slot_en;
  logic [NSRC-1:0]     i_src_valid;
  logic [NSRC*W-1:0]   i_src_data;
  logic [NSRC-1:0]     o_src_ready;
  logic [W-1:0]        o_freq_fdata;
  logic                o_freq_ffram;
  logic                o_busy;
  logic [NSRC-1:0]     o_underrun;
`ifdef UL_TDM_UNDERRUN_CNT_EN
  logic [NSRC*16-1:0]  o_underrun_cnt;
`endif

  modport slave (
    input  i_en, i_slot_map, i_slot_en, i_src_valid, i_src_data,
    output o_src_ready, o_freq_fdata, o_freq_ffram, o_busy, o_underrun
`ifdef UL_TDM_UNDERRUN_CNT_EN
    , output o_underrun_cnt
`endif
  );

  modport master (
    output i_en, i_slot_map, i_slot_en, i_src_valid, i_src_data,
    input  o_src_ready, o_freq_fdata, o_freq_ffram, o_busy, o_underrun
`ifdef UL_TDM_UNDERRUN_CNT_EN
    , input o_underrun_cnt
`endif
  );
endinterface

// File: rtl/ul_tdm_sched.sv
// Uplink TDM scheduler: 8-slot frame shared by four requesters via a frame-latched slot map.
// Define UL_TDM_UNDERRUN_CNT_EN to add per-source 16-bit saturating underrun counters.
module ul_tdm_sched #(
  parameter int NSRC = 4,
  parameter int W    = 32
) (
  input  logic           clk_491,
  input  logic           rst_491,
  ul_tdm_sched_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      slot_reg, slot_next;
  logic [15:0]     map_reg, map_next;
  logic [7:0]      ena_reg, ena_next;
  logic [W-1:0]    fdata_reg, fdata_next;
  logic            ffram_reg, ffram_next;
  logic [NSRC-1:0] und_reg, und_next, und_set;
  logic            en_prev_reg;
  logic            en_rise;
  logic [1:0]      owner;
  logic            slot_on;
  logic [NSRC-1:0] ready;
  logic [W-1:0]    src_word [NSRC];

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_word
      assign src_word[gi] = bus.i_src_data[gi*W +: W];
    end
  endgenerate

  assign owner   = map_reg[{slot_reg, 1'b0} +: 2];
  assign slot_on = (state_reg == RUN) && ena_reg[slot_reg];
  assign en_rise = bus.i_en && !en_prev_reg;

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    map_next   = map_reg;
    ena_next   = ena_reg;
    ready      = '0;
    und_set    = '0;
    fdata_next = '0;
    ffram_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.i_en) begin
          state_next = RUN;
          slot_next  = 3'd0;
          map_next   = bus.i_slot_map;
          ena_next   = bus.i_slot_en;
        end
      end
      RUN: begin
        ffram_next = (slot_reg == 3'd0);
        slot_next  = slot_reg + 3'd1;
        if (slot_on) begin
          if (bus.i_src_valid[owner]) begin
            ready[owner] = 1'b1;
            fdata_next   = src_word[owner];
          end else begin
            und_set[owner] = 1'b1;
          end
        end
        // Config only changes at the frame boundary; the run decision is made here too.
        if (slot_reg == 3'd7) begin
          map_next = bus.i_slot_map;
          ena_next = bus.i_slot_en;
          if (!bus.i_en) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    und_next = (en_rise ? '0 : und_reg) | und_set;
  end

  always_ff @(posedge clk_491 or posedge rst_491) begin
    if (rst_491) begin
      state_reg   <= IDLE;
      slot_reg    <= 3'd0;
      map_reg     <= '0;
      ena_reg     <= '0;
      fdata_reg   <= '0;
      ffram_reg   <= 1'b0;
      und_reg     <= '0;
      en_prev_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      slot_reg    <= slot_next;
      map_reg     <= map_next;
      ena_reg     <= ena_next;
      fdata_reg   <= fdata_next;
      ffram_reg   <= ffram_next;
      und_reg     <= und_next;
      en_prev_reg <= bus.i_en;
    end
  end

`ifdef UL_TDM_UNDERRUN_CNT_EN
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_cnt
      logic [15:0] cnt_reg, cnt_next;
      // A clear coinciding with an underrun leaves a count of one.
      always_comb begin
        cnt_next = cnt_reg;
        if (en_rise)
          cnt_next = {15'd0, und_set[gi]};
        else if (und_set[gi] && (cnt_reg != 16'hFFFF))
          cnt_next = cnt_reg + 16'd1;
      end
      always_ff @(posedge clk_491 or posedge rst_491) begin
        if (rst_491) cnt_reg <= '0;
        else         cnt_reg <= cnt_next;
      end
      assign bus.o_underrun_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

  assign bus.o_src_ready  = ready;
  assign bus.o_freq_fdata = fdata_reg;
  assign bus.o_freq_ffram = ffram_reg;
  assign bus.o_busy       = (state_reg == RUN);
  assign bus.o_underrun   = und_reg;
endmodule

// File: tb/tb_ul_tdm_sched.sv
// Self-checking bench for ul_tdm_sched: frame-level reference model, directed scenarios, random traffic.
// Counter checks are compiled in when UL_TDM_UNDERRUN_CNT_EN is defined.
module tb_ul_tdm_sched;
  logic clk_491 = 1'b0;
  logic rst_491 = 1'b0;

  ul_tdm_sched_if #(.NSRC(4), .W(32)) bus ();
  ul_tdm_sched #(.NSRC(4), .W(32)) dut (.clk_491(clk_491), .rst_491(rst_491), .bus(bus));

  always #5 clk_491 = ~clk_491;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit verbose  = 1'b0;

  // Reference model: frame position, frame-latched config and expected registered outputs.
  bit          m_run;
  int          m_pos;
  int          m_map [8];
  bit          m_ena [8];
  logic [31:0] m_fdata;
  bit          m_ffram;
  bit   [3:0]  m_und;
  bit          m_prev_en;
  int          m_cnt [4];
  bit   [3:0]  m_pop;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %h, want %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lit_word(input int k);
    return 32'hA000_0000 | (32'(k) * 32'h1111);
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_fdata = '0; m_ffram = 0; m_und = '0; m_prev_en = 0; m_pop = '0;
    for (int s = 0; s < 8; s++) begin m_map[s] = 0; m_ena[s] = 0; end
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  task automatic model_latch();
    for (int s = 0; s < 8; s++) begin
      m_map[s] = int'((bus.i_slot_map >> (2 * s)) & 16'h3);
      m_ena[s] = bus.i_slot_en[s];
    end
  endtask

  function automatic logic [3:0] exp_ready();
    logic [3:0] r = '0;
    if (m_run && m_ena[m_pos] && bus.i_src_valid[m_map[m_pos]]) r[m_map[m_pos]] = 1'b1;
    return r;
  endfunction

  task automatic model_update();
    bit [3:0]    set  = '0;
    logic [31:0] w    = '0;
    bit          fr   = 0;
    bit          rise = bus.i_en && !m_prev_en;
    m_pop = '0;
    if (!m_run) begin
      if (bus.i_en) begin m_run = 1; m_pos = 0; model_latch(); end
    end else begin
      int k = m_map[m_pos];
      fr = (m_pos == 0);
      if (m_ena[m_pos]) begin
        if (bus.i_src_valid[k]) begin
          w = bus.i_src_data[k*32 +: 32];
          m_pop[k] = 1;
          if (verbose) $display("xfer slot %0d src %0d word %h", m_pos, k, w);
        end else set[k] = 1;
      end
      if (m_pos == 7) begin
        model_latch();
        if (!bus.i_en) m_run = 0;
      end
      m_pos = (m_pos + 1) % 8;
    end
    m_fdata = w;
    m_ffram = fr;
    for (int k = 0; k < 4; k++) begin
      if (rise) begin
        m_und[k] = set[k];
        m_cnt[k] = set[k] ? 1 : 0;
      end else if (set[k]) begin
        m_und[k] = 1;
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end
    end
    m_prev_en = bus.i_en;
  endtask

  // One clock: check combinational ready, advance model at the edge, check registered outputs.
  task automatic cycle();
    #2;
    chk("src_ready", 64'(bus.o_src_ready), 64'(exp_ready()));
    @(posedge clk_491);
    model_update();
    #1;
    chk("fdata", 64'(bus.o_freq_fdata), 64'(m_fdata));
    chk("ffram", 64'(bus.o_freq_ffram), 64'(m_ffram));
    chk("busy", 64'(bus.o_busy), 64'(m_run));
    chk("underrun", 64'(bus.o_underrun), 64'(m_und));
`ifdef UL_TDM_UNDERRUN_CNT_EN
    for (int k = 0; k < 4; k++)
      chk("underrun_cnt", 64'(bus.o_underrun_cnt[k*16 +: 16]), 64'(m_cnt[k]));
`endif
  endtask

  task automatic set_const_sources(input logic [3:0] val);
    bus.i_src_valid = val;
    for (int k = 0; k < 4; k++) bus.i_src_data[k*32 +: 32] = lit_word(k);
  endtask

  task automatic wait_idle();
    bus.i_en = 1'b0;
    for (int i = 0; i < 20 && bus.o_busy; i++) cycle();
    chk("idle_reached", 64'(bus.o_busy), 64'd0);
  endtask

  // Leaves the DUT in the slot-0 cycle of a fresh run with the given config.
  task automatic start_fresh(input logic [15:0] map, input logic [7:0] sen, input logic [3:0] val);
    wait_idle();
    bus.i_slot_map = map;
    bus.i_slot_en  = sen;
    set_const_sources(val);
    cycle();
    bus.i_en = 1'b1;
    cycle();
  endtask

  initial begin
    logic [31:0] e;
    bus.i_en = 0; bus.i_slot_map = '0; bus.i_slot_en = '0; bus.i_src_valid = '0; bus.i_src_data = '0;
    model_reset();
    #2 rst_491 = 1'b1;
    #1;
    chk("rst_fdata", 64'(bus.o_freq_fdata), 64'd0);
    chk("rst_ffram", 64'(bus.o_freq_ffram), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_underrun", 64'(bus.o_underrun), 64'd0);
    chk("rst_ready", 64'(bus.o_src_ready), 64'd0);
    repeat (2) @(posedge clk_491);
    #2 rst_491 = 1'b0;
    verbose = 1'b1;

    // Round-robin map, then a mid-frame map change that must wait for the next frame.
    start_fresh(16'hE4E4, 8'hFF, 4'hF);
    for (int j = 0; j < 24; j++) begin
      if (j == 11) bus.i_slot_map = 16'h0000;
      cycle();
      e = (j < 16) ? lit_word(j % 4) : lit_word(0);
      chk("rr_word", 64'(bus.o_freq_fdata), 64'(e));
      chk("rr_ffram", 64'(bus.o_freq_ffram), 64'((j % 8) == 0));
    end

    // Half the slots disabled.
    start_fresh(16'hE4E4, 8'h0F, 4'hF);
    for (int j = 0; j < 8; j++) begin
      cycle();
      e = (j < 4) ? lit_word(j) : 32'd0;
      chk("slot_en_word", 64'(bus.o_freq_fdata), 64'(e));
    end
    chk("slot_en_no_underrun", 64'(bus.o_underrun), 64'd0);

    // Source 2 idle while owning only slot 2; then a mid-frame en re-rise clears.
    start_fresh(16'hF4E4, 8'hFF, 4'b1011);
    repeat (24) cycle();
    chk("und_flag", 64'(bus.o_underrun), 64'h4);
`ifdef UL_TDM_UNDERRUN_CNT_EN
    chk("und_cnt3", 64'(bus.o_underrun_cnt[2*16 +: 16]), 64'd3);
`endif
    bus.i_en = 1'b0;
    cycle();
    bus.i_en = 1'b1;
    cycle();
    chk("und_cleared", 64'(bus.o_underrun), 64'd0);
`ifdef UL_TDM_UNDERRUN_CNT_EN
    chk("und_cnt_cleared", 64'(bus.o_underrun_cnt[2*16 +: 16]), 64'd0);
`endif

    // en dropped at slot 2: frame still completes.
    start_fresh(16'hE4E4, 8'hFF, 4'hF);
    repeat (2) cycle();
    bus.i_en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 5) chk("drop_busy_hi", 64'(bus.o_busy), 64'd1);
    end
    chk("drop_busy_lo", 64'(bus.o_busy), 64'd0);
    chk("drop_last_word", 64'(bus.o_freq_fdata), 64'(lit_word(3)));
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("drop_no_ffram", 64'(bus.o_freq_ffram), 64'd0);
      chk("drop_fdata0", 64'(bus.o_freq_fdata), 64'd0);
    end

    // Asynchronous reset in slot 3.
    start_fresh(16'hE4E4, 8'hFF, 4'hF);
    repeat (3) cycle();
    #1 rst_491 = 1'b1;
    #1;
    chk("arst_fdata", 64'(bus.o_freq_fdata), 64'd0);
    chk("arst_busy", 64'(bus.o_busy), 64'd0);
    chk("arst_ready", 64'(bus.o_src_ready), 64'd0);
    chk("arst_ffram", 64'(bus.o_freq_ffram), 64'd0);
    model_reset();
    @(posedge clk_491);
    #2 rst_491 = 1'b0;
    cycle();
    chk("arst_ffram_c1", 64'(bus.o_freq_ffram), 64'd0);
    cycle();
    chk("arst_ffram_c2", 64'(bus.o_freq_ffram), 64'd1);
    chk("arst_word0", 64'(bus.o_freq_fdata), 64'(lit_word(0)));

    // Random traffic with sources honouring the hold-until-ready rule.
    verbose = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.i_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) bus.i_slot_map = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.i_slot_en  = 8'($urandom | $urandom);
      for (int k = 0; k < 4; k++) begin
        if (!bus.i_src_valid[k] || m_pop[k]) begin
          bus.i_src_valid[k] = ($urandom_range(0, 3) != 0);
          bus.i_src_data[k*32 +: 32] = $urandom;
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
